// File: rtl/mem_arbiter_if.sv
// Cache request/response channels and main-memory port seen by mem_arbiter.
// master: the arbiter's view; slave: the caches and memory surrounding it.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3
);
  // Handshake: a cache request is a level held (with addr/data) until its status
  // reads 10 (done) or 11 (error); it drops or changes only in the following cycle.
  logic [1:0]                  i_cache_mem_vis_signal;
  logic [ADDR_WIDTH-1:0]       i_cache_mem_vis_addr;
  logic [1:0]                  d_cache_mem_vis_signal;
  logic [ADDR_WIDTH-1:0]       d_cache_mem_vis_addr;
  logic [LEN-1:0]              d_cache_written_data;
  logic [2:0]                  d_cache_data_type;
  logic [ENTRY_INDEX_SIZE:0]   d_cache_write_length;
  logic [LEN-1:0]              mem_data;
  logic [1:0]                  mem_status;
  logic [1:0]                  mem_vis_signal;
  logic [ADDR_WIDTH-1:0]       mem_vis_addr;
  logic [LEN-1:0]              mem_written_data;
  logic [2:0]                  mem_data_type;
  logic [ENTRY_INDEX_SIZE:0]   mem_write_length;
  logic [LEN-1:0]              i_cache_mem_data;
  logic [1:0]                  i_cache_mem_status;
  logic [LEN-1:0]              d_cache_mem_data;
  logic [1:0]                  d_cache_mem_status;

  modport master (
    input  i_cache_mem_vis_signal, i_cache_mem_vis_addr,
    input  d_cache_mem_vis_signal, d_cache_mem_vis_addr, d_cache_written_data,
    input  d_cache_data_type, d_cache_write_length, mem_data, mem_status,
    output mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type,
    output mem_write_length, i_cache_mem_data, i_cache_mem_status,
    output d_cache_mem_data, d_cache_mem_status
  );

  modport slave (
    output i_cache_mem_vis_signal, i_cache_mem_vis_addr,
    output d_cache_mem_vis_signal, d_cache_mem_vis_addr, d_cache_written_data,
    output d_cache_data_type, d_cache_write_length, mem_data, mem_status,
    input  mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type,
    input  mem_write_length, i_cache_mem_data, i_cache_mem_status,
    input  d_cache_mem_data, d_cache_mem_status
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting the single main-memory port to the I-cache or D-cache.
// Optional ARB_WATCHDOG_EN: abort a BUSY access with status 11 after TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic [1:0]    state_o
);
  localparam int WL = ENTRY_INDEX_SIZE + 1;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_BUSY = 2'b01, ST_DONE = 2'b10, ST_ERR = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;        // 0: I-cache wins the next tie
  logic                  gnt_q, gnt_d;      // granted side, 1: D-cache
  logic                  first_q, first_d;
  logic [1:0]            mem_sig_q, mem_sig_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LEN-1:0]        mem_wdata_q, mem_wdata_d;
  logic [2:0]            mem_type_q, mem_type_d;
  logic [WL-1:0]         mem_len_q, mem_len_d;
  logic [LEN-1:0]        i_data_q, i_data_d, d_data_q, d_data_d;
  logic [1:0]            i_st_q, i_st_d, d_st_q, d_st_d;
  logic                  i_req, d_req, mem_done, timeout;

  assign i_req    = (bus.i_cache_mem_vis_signal == 2'b01);
  assign d_req    = (bus.d_cache_mem_vis_signal == 2'b01) || (bus.d_cache_mem_vis_signal == 2'b10);
  // A done still showing from the previous access must not complete the new one.
  assign mem_done = !first_q && (bus.mem_status == 2'b10);

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    first_d     = 1'b0;
    mem_sig_d   = mem_sig_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_type_d  = mem_type_q;
    mem_len_d   = mem_len_q;
    i_data_d    = i_data_q;
    d_data_d    = d_data_q;
    i_st_d      = i_req ? ST_BUSY : ST_IDLE;
    d_st_d      = d_req ? ST_BUSY : ST_IDLE;
`ifdef ARB_WATCHDOG_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = d_req && (!i_req || rr_q);
          state_d = BUSY;
          first_d = 1'b1;
          if (i_req && d_req) rr_d = ~rr_q;
`ifdef ARB_WATCHDOG_EN
          cnt_d = '0;
`endif
          if (gnt_d) begin
            mem_sig_d   = bus.d_cache_mem_vis_signal;
            mem_addr_d  = bus.d_cache_mem_vis_addr;
            mem_wdata_d = bus.d_cache_written_data;
            mem_type_d  = bus.d_cache_data_type;
            mem_len_d   = bus.d_cache_write_length;
          end else begin
            // I-cache refills carry no payload; the write fields are zeroed.
            mem_sig_d   = 2'b01;
            mem_addr_d  = bus.i_cache_mem_vis_addr;
            mem_wdata_d = '0;
            mem_type_d  = '0;
            mem_len_d   = '0;
          end
        end
      end
      BUSY: begin
        if (gnt_q) d_st_d = ST_BUSY; else i_st_d = ST_BUSY;
        if (mem_done) begin
          mem_sig_d = 2'b00;
          state_d   = RESP;
          if (gnt_q) begin
            d_data_d = bus.mem_data;
            d_st_d   = ST_DONE;
          end else begin
            i_data_d = bus.mem_data;
            i_st_d   = ST_DONE;
          end
        end else if (timeout) begin
          mem_sig_d = 2'b00;
          state_d   = RESP;
          if (gnt_q) d_st_d = ST_ERR; else i_st_d = ST_ERR;
        end else begin
`ifdef ARB_WATCHDOG_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        if (gnt_q) d_st_d = ST_IDLE; else i_st_d = ST_IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      first_q     <= 1'b0;
      mem_sig_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_type_q  <= '0;
      mem_len_q   <= '0;
      i_data_q    <= '0;
      d_data_q    <= '0;
      i_st_q      <= '0;
      d_st_q      <= '0;
`ifdef ARB_WATCHDOG_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      first_q     <= first_d;
      mem_sig_q   <= mem_sig_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_type_q  <= mem_type_d;
      mem_len_q   <= mem_len_d;
      i_data_q    <= i_data_d;
      d_data_q    <= d_data_d;
      i_st_q      <= i_st_d;
      d_st_q      <= d_st_d;
`ifdef ARB_WATCHDOG_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.mem_vis_signal     = mem_sig_q;
  assign bus.mem_vis_addr       = mem_addr_q;
  assign bus.mem_written_data   = mem_wdata_q;
  assign bus.mem_data_type      = mem_type_q;
  assign bus.mem_write_length   = mem_len_q;
  assign bus.i_cache_mem_data   = i_data_q;
  assign bus.i_cache_mem_status = i_st_q;
  assign bus.d_cache_mem_data   = d_data_q;
  assign bus.d_cache_mem_status = d_st_q;
  assign state_o                = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, per-cache drivers, grant/data scoreboards, report.
// The watchdog scenario is included when ARB_WATCHDOG_EN is defined.
module tb_mem_arbiter;
  localparam int AW  = 17;
  localparam int LEN = 32;
  localparam int EIS = 3;
  localparam int WL  = EIS + 1;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state;
  int         checks = 0;
  int         errors = 0;
  int         mem_lat = 3;
  int         mem_cnt = 0;
  bit         g_check_en = 1'b1;
  bit         wd_ok = 1'b0;
  int         mode;
  logic [AW-1:0]  ra_i, ra_d;
  logic [LEN-1:0] rw_d;
  logic [1:0]     rs_d;

  logic [LEN-1:0] exp_i_q[$];
  logic [LEN-1:0] exp_d_q[$];
  logic [63:0]    exp_g_q[$];

  mem_arbiter_if #(.ADDR_WIDTH(AW), .LEN(LEN), .ENTRY_INDEX_SIZE(EIS)) bus();

  mem_arbiter #(.ADDR_WIDTH(AW), .LEN(LEN), .ENTRY_INDEX_SIZE(EIS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LEN-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [63:0] grec(input logic [1:0] s, input logic [AW-1:0] a,
                                       input logic [LEN-1:0] w, input logic [2:0] t,
                                       input logic [WL-1:0] l);
    return {6'd0, s, a, w, t, l};
  endfunction

  // Memory model: done (with a word derived from the address) mem_lat cycles after a request appears.
  initial begin
    bus.mem_status = 2'b00;
    bus.mem_data   = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || bus.mem_vis_signal == 2'b00) begin
        mem_cnt = 0;
        bus.mem_status = 2'b00;
      end else begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          bus.mem_status = 2'b10;
          bus.mem_data   = mem_word(bus.mem_vis_addr);
        end else begin
          bus.mem_status = 2'b01;
        end
      end
    end
  end

  // Monitor: grant order/content, mem_* stability, completion data and pulse width.
  initial begin
    logic [63:0] cur, held;
    logic [1:0]  prev_sig, prev_i, prev_d;
    prev_sig = 2'b00; prev_i = 2'b00; prev_d = 2'b00; held = '0;
    forever begin
      @(negedge clk);
      cur = grec(bus.mem_vis_signal, bus.mem_vis_addr, bus.mem_written_data,
                 bus.mem_data_type, bus.mem_write_length);
      if (bus.mem_vis_signal != 2'b00) begin
        if (prev_sig == 2'b00) begin
          if (g_check_en) begin
            if (exp_g_q.size() == 0) check("grant_unexpected", cur, 64'd0);
            else check("grant", cur, exp_g_q.pop_front());
          end
          held = cur;
        end else begin
          check("mem_hold", cur, held);
        end
      end
      if (prev_i[1]) check("i_status_pulse", 64'(bus.i_cache_mem_status), 64'd0);
      if (prev_d[1]) check("d_status_pulse", 64'(bus.d_cache_mem_status), 64'd0);
      if (bus.i_cache_mem_status == 2'b10 && prev_i != 2'b10) begin
        if (exp_i_q.size() == 0) check("i_done_unexpected", 64'(bus.i_cache_mem_status), 64'd0);
        else check("i_data", 64'(bus.i_cache_mem_data), 64'(exp_i_q.pop_front()));
      end
      if (bus.d_cache_mem_status == 2'b10 && prev_d != 2'b10) begin
        if (exp_d_q.size() == 0) check("d_done_unexpected", 64'(bus.d_cache_mem_status), 64'd0);
        else check("d_data", 64'(bus.d_cache_mem_data), 64'(exp_d_q.pop_front()));
      end
      if (bus.i_cache_mem_status == 2'b11 && !wd_ok) check("i_error", 64'(bus.i_cache_mem_status), 64'd0);
      if (bus.d_cache_mem_status == 2'b11 && !wd_ok) check("d_error", 64'(bus.d_cache_mem_status), 64'd0);
      prev_sig = bus.mem_vis_signal;
      prev_i   = bus.i_cache_mem_status;
      prev_d   = bus.d_cache_mem_status;
    end
  end

  task automatic wait_status(input bit side, output logic [1:0] st);
    int    n;
    string tag;
    n  = 0;
    st = 2'b00;
    while (n < 300) begin
      @(negedge clk);
      st = side ? bus.d_cache_mem_status : bus.i_cache_mem_status;
      if (st[1]) break;
      n++;
    end
    tag = side ? "d_wait_timeout" : "i_wait_timeout";
    if (!st[1]) check(tag, 64'(st), 64'h2);
  endtask

  task automatic i_access(input logic [AW-1:0] a);
    logic [1:0] st;
    bus.i_cache_mem_vis_signal = 2'b01;
    bus.i_cache_mem_vis_addr   = a;
    exp_i_q.push_back(mem_word(a));
    wait_status(1'b0, st);
    @(posedge clk); #1;
    bus.i_cache_mem_vis_signal = 2'b00;
  endtask

  task automatic d_access(input logic [1:0] s, input logic [AW-1:0] a, input logic [LEN-1:0] w,
                          input logic [2:0] t, input logic [WL-1:0] l);
    logic [1:0] st;
    bus.d_cache_mem_vis_signal = s;
    bus.d_cache_mem_vis_addr   = a;
    bus.d_cache_written_data   = w;
    bus.d_cache_data_type      = t;
    bus.d_cache_write_length   = l;
    exp_d_q.push_back(mem_word(a));
    wait_status(1'b1, st);
    @(posedge clk); #1;
    bus.d_cache_mem_vis_signal = 2'b00;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string p);
    check({p, "_sig"},    64'(bus.mem_vis_signal), 64'd0);
    check({p, "_addr"},   64'(bus.mem_vis_addr), 64'd0);
    check({p, "_wdata"},  64'(bus.mem_written_data), 64'd0);
    check({p, "_type"},   64'(bus.mem_data_type), 64'd0);
    check({p, "_len"},    64'(bus.mem_write_length), 64'd0);
    check({p, "_i_data"}, 64'(bus.i_cache_mem_data), 64'd0);
    check({p, "_i_st"},   64'(bus.i_cache_mem_status), 64'd0);
    check({p, "_d_data"}, 64'(bus.d_cache_mem_data), 64'd0);
    check({p, "_d_st"},   64'(bus.d_cache_mem_status), 64'd0);
    check({p, "_state"},  64'(state), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.i_cache_mem_vis_signal = 2'b00;
    bus.i_cache_mem_vis_addr   = '0;
    bus.d_cache_mem_vis_signal = 2'b00;
    bus.d_cache_mem_vis_addr   = '0;
    bus.d_cache_written_data   = '0;
    bus.d_cache_data_type      = '0;
    bus.d_cache_write_length   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single I-cache read, memory done three cycles after the grant.
    mem_lat = 3;
    bus.i_cache_mem_vis_signal = 2'b01;
    bus.i_cache_mem_vis_addr   = 17'h00100;
    exp_i_q.push_back(mem_word(17'h00100));
    exp_g_q.push_back(grec(2'b01, 17'h00100, '0, '0, '0));
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t1_i_busy", 64'(bus.i_cache_mem_status), 64'd1);
      check("t1_d_idle", 64'(bus.d_cache_mem_status), 64'd0);
      check("t1_state_busy", 64'(state), 64'd1);
    end
    @(negedge clk);
    check("t1_i_done", 64'(bus.i_cache_mem_status), 64'd2);
    check("t1_i_word", 64'(bus.i_cache_mem_data), 64'(mem_word(17'h00100)));
    check("t1_d_idle2", 64'(bus.d_cache_mem_status), 64'd0);
    check("t1_sig_off", 64'(bus.mem_vis_signal), 64'd0);
    @(posedge clk); #1;
    bus.i_cache_mem_vis_signal = 2'b00;
    @(negedge clk);
    check("t1_i_after", 64'(bus.i_cache_mem_status), 64'd0);
    check("t1_state_idle", 64'(state), 64'd0);
    check("t1_i_data_held", 64'(bus.i_cache_mem_data), 64'(mem_word(17'h00100)));
    @(posedge clk); #1;

    // Simultaneous I and D after reset: I first, D waits with status 01.
    apply_reset();
    exp_g_q.push_back(grec(2'b01, 17'h00300, '0, '0, '0));
    exp_g_q.push_back(grec(2'b01, 17'h00400, 32'h1111_2222, 3'b010, 4'd4));
    fork
      i_access(17'h00300);
      d_access(2'b01, 17'h00400, 32'h1111_2222, 3'b010, 4'd4);
      begin
        @(posedge clk);
        @(negedge clk);
        check("t2_d_waiting", 64'(bus.d_cache_mem_status), 64'd1);
        check("t2_i_granted", 64'(bus.i_cache_mem_status), 64'd1);
        check("t2_addr_i", 64'(bus.mem_vis_addr), 64'h00300);
      end
    join

    // Back-to-back contention: grants alternate I, D, I, D.
    apply_reset();
    mem_lat = 4;
    exp_g_q.push_back(grec(2'b01, 17'h00A00, '0, '0, '0));
    exp_g_q.push_back(grec(2'b01, 17'h00B00, 32'h0000_0001, 3'b001, 4'd2));
    exp_g_q.push_back(grec(2'b01, 17'h00A40, '0, '0, '0));
    exp_g_q.push_back(grec(2'b01, 17'h00B40, 32'h0000_0002, 3'b001, 4'd2));
    fork
      begin
        i_access(17'h00A00);
        i_access(17'h00A40);
      end
      begin
        d_access(2'b01, 17'h00B00, 32'h0000_0001, 3'b001, 4'd2);
        d_access(2'b01, 17'h00B40, 32'h0000_0002, 3'b001, 4'd2);
      end
    join

    // D-cache write; I-cache status untouched.
    mem_lat = 3;
    exp_g_q.push_back(grec(2'b10, 17'h00200, 32'hDEAD_BEEF, 3'b010, 4'd4));
    fork
      d_access(2'b10, 17'h00200, 32'hDEAD_BEEF, 3'b010, 4'd4);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check("t4_i_idle", 64'(bus.i_cache_mem_status), 64'd0);
      end
    join

    // Reset in the second BUSY cycle aborts the access; a re-issue is served.
    mem_lat = 1000;
    bus.i_cache_mem_vis_signal = 2'b01;
    bus.i_cache_mem_vis_addr   = 17'h00C00;
    exp_g_q.push_back(grec(2'b01, 17'h00C00, '0, '0, '0));
    @(posedge clk);
    @(negedge clk);
    check("t5_busy", 64'(state), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_cache_mem_vis_signal = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check_zero("t5_abort");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_lat = 3;
    exp_g_q.push_back(grec(2'b01, 17'h00C00, '0, '0, '0));
    i_access(17'h00C00);

`ifdef ARB_WATCHDOG_EN
    // Memory never answers: status 11 after TIMEOUT_CYCLES busy cycles.
    wd_ok   = 1'b1;
    mem_lat = 1000;
    bus.d_cache_mem_vis_signal = 2'b01;
    bus.d_cache_mem_vis_addr   = 17'h00D00;
    bus.d_cache_written_data   = '0;
    bus.d_cache_data_type      = '0;
    bus.d_cache_write_length   = '0;
    exp_g_q.push_back(grec(2'b01, 17'h00D00, '0, '0, '0));
    @(posedge clk);
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check("wd_busy", 64'(bus.d_cache_mem_status), 64'd1);
    end
    @(negedge clk);
    check("wd_error", 64'(bus.d_cache_mem_status), 64'd3);
    check("wd_sig_off", 64'(bus.mem_vis_signal), 64'd0);
    @(posedge clk); #1;
    bus.d_cache_mem_vis_signal = 2'b00;
    @(negedge clk);
    check("wd_clear", 64'(bus.d_cache_mem_status), 64'd0);
    @(posedge clk); #1;
    wd_ok   = 1'b0;
    mem_lat = 3;
    exp_g_q.push_back(grec(2'b01, 17'h00D40, 32'h5, 3'b000, 4'd1));
    d_access(2'b01, 17'h00D40, 32'h5, 3'b000, 4'd1);
`endif

    // Random mix of single and contending accesses; data scoreboard only.
    g_check_en = 1'b0;
    for (int r = 0; r < 8; r++) begin
      mem_lat = $urandom_range(2, 6);
      mode    = $urandom_range(0, 2);
      ra_i    = AW'($urandom());
      ra_d    = AW'($urandom());
      rw_d    = $urandom();
      rs_d    = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      fork
        begin
          if (mode != 1) i_access(ra_i);
        end
        begin
          if (mode != 0) d_access(rs_d, ra_d, rw_d, 3'b100, 4'd8);
        end
      join
    end

    repeat (3) @(negedge clk);
    check("exp_i_empty", 64'(exp_i_q.size()), 64'd0);
    check("exp_d_empty", 64'(exp_d_q.size()), 64'd0);
    check("exp_g_empty", 64'(exp_g_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
